bomberman_collision: RTL and testbench

- Produces the 4-bit `bomberman_blocked` vector consumed by the bomberman movement block.
- Snapshots the sprite's top-left position (`b_x`, `b_y`) and probes the tile-map RAM at 8 pixels lying one pixel outside the 16x16 sprite edges.
- Reports, per direction, whether any probe hits a non-empty tile or falls outside the arena.
- Runs continuously while enabled; results refresh every 11 cycles.

---
 rtl/bomberman_pkg.sv | 29 ++
 rtl/bomberman_probe_addr.sv | 30 +++
 rtl/bomberman_collision.sv | 121 ++++++++++++
 tb/tb_bomberman_collision.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared arena geometry, tile codes, direction indices and FSM states
// for the bomberman collision scanner.
package bomberman_pkg;

   localparam int MAP_X0   = 144;
   localparam int MAP_Y0   = 144;
   localparam int TILE_SH  = 4;
   localparam int MAP_COLS = 37;
   localparam int MAP_ROWS = 22;
   localparam int B_W      = 16;

   localparam logic [1:0] TILE_EMPTY = 2'd0;
   localparam logic [1:0] TILE_HARD  = 2'd1;
   localparam logic [1:0] TILE_SOFT  = 2'd2;
   localparam logic [1:0] TILE_BOMB  = 2'd3;

   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_UP    = 2;
   localparam int DIR_DOWN  = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PROBE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

endpackage

// File: rtl/bomberman_probe_addr.sv
// Maps an arena pixel to its tile-RAM index, flagging pixels outside the arena.
module bomberman_probe_addr
   import bomberman_pkg::*;
(
   input  logic [10:0] px,
   input  logic [10:0] py,
   output logic [9:0]  addr,
   output logic        oob
);

   localparam logic [10:0] X_LO = 11'(MAP_X0);
   localparam logic [10:0] X_HI = 11'(MAP_X0 + (MAP_COLS << TILE_SH));
   localparam logic [10:0] Y_LO = 11'(MAP_Y0);
   localparam logic [10:0] Y_HI = 11'(MAP_Y0 + (MAP_ROWS << TILE_SH));

   logic [10:0] dx;
   logic [10:0] dy;
   logic [5:0]  col;
   logic [4:0]  row;

   assign dx  = px - X_LO;
   assign dy  = py - Y_LO;
   // Column/row are only meaningful when the pixel is inside the arena.
   assign col = 6'(dx >> TILE_SH);
   assign row = 5'(dy >> TILE_SH);

   assign addr = 10'(row) * 10'(MAP_COLS) + 10'(col);
   assign oob  = (px < X_LO) || (px >= X_HI) || (py < Y_LO) || (py >= Y_HI);

endmodule

// File: rtl/bomberman_collision.sv
// Scans 8 pixels just outside the sprite edges against the tile map and
// publishes a per-direction blocked vector every 11 cycles while enabled.
module bomberman_collision
   import bomberman_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   output logic       map_rd_en,
   output logic [9:0] map_addr,
   input  logic [1:0] map_rd_data,
   output logic [3:0] bomberman_blocked,
   output logic       scan_done,
   output logic [1:0] fsm_state
);

   state_t      state;
   logic [2:0]  k;
   logic [9:0]  sx;
   logic [9:0]  sy;
   logic [7:0]  hit;
   logic [2:0]  k_d;
   logic        v_d;
   logic [9:0]  addr_hold;

   logic [10:0] sx11;
   logic [10:0] sy11;
   logic [10:0] px;
   logic [10:0] py;
   logic [9:0]  p_addr;
   logic        p_oob;

   assign sx11 = {1'b0, sx};
   assign sy11 = {1'b0, sy};

   always_comb begin
      px = sx11;
      py = sy11;
      case (k)
         3'd0: begin px = sx11 - 11'd1;        py = sy11;                 end
         3'd1: begin px = sx11 - 11'd1;        py = sy11 + 11'(B_W - 1);  end
         3'd2: begin px = sx11 + 11'(B_W);     py = sy11;                 end
         3'd3: begin px = sx11 + 11'(B_W);     py = sy11 + 11'(B_W - 1);  end
         3'd4: begin px = sx11;                py = sy11 - 11'd1;         end
         3'd5: begin px = sx11 + 11'(B_W - 1); py = sy11 - 11'd1;         end
         3'd6: begin px = sx11;                py = sy11 + 11'(B_W);      end
         default: begin px = sx11 + 11'(B_W - 1); py = sy11 + 11'(B_W);  end
      endcase
   end

   bomberman_probe_addr u_probe_addr (
      .px   (px),
      .py   (py),
      .addr (p_addr),
      .oob  (p_oob)
   );

   // Out-of-arena probes never touch the RAM; the address bus keeps its last value.
   assign map_rd_en = (state == ST_PROBE) && !p_oob;
   assign map_addr  = map_rd_en ? p_addr : addr_hold;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= ST_IDLE;
         k                 <= 3'd0;
         sx                <= 10'd0;
         sy                <= 10'd0;
         hit               <= 8'd0;
         k_d               <= 3'd0;
         v_d               <= 1'b0;
         addr_hold         <= 10'd0;
         bomberman_blocked <= 4'b1111;
         scan_done         <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         v_d       <= 1'b0;
         // Read data returns one cycle after its strobe; file it under the delayed index.
         if (v_d)
            hit[k_d] <= (map_rd_data != TILE_EMPTY);
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  sx    <= b_x;
                  sy    <= b_y;
                  k     <= 3'd0;
                  state <= ST_PROBE;
               end
            end
            ST_PROBE: begin
               if (p_oob) begin
                  hit[k] <= 1'b1;
               end else begin
                  v_d       <= 1'b1;
                  k_d       <= k;
                  addr_hold <= p_addr;
               end
               if (k == 3'd7)
                  state <= ST_WAIT;
               else
                  k <= k + 3'd1;
            end
            ST_WAIT: begin
               state <= ST_UPDATE;
            end
            default: begin
               bomberman_blocked[DIR_LEFT]  <= hit[0] | hit[1];
               bomberman_blocked[DIR_RIGHT] <= hit[2] | hit[3];
               bomberman_blocked[DIR_UP]    <= hit[4] | hit[5];
               bomberman_blocked[DIR_DOWN]  <= hit[6] | hit[7];
               scan_done <= 1'b1;
               hit       <= 8'd0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bomberman_collision.sv
// Directed and randomized scans of bomberman_collision against a pixel/tile model.
module tb_bomberman_collision;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [9:0] b_x;
   logic [9:0] b_y;
   logic       map_rd_en;
   logic [9:0] map_addr;
   logic [1:0] map_rd_data;
   logic [3:0] bomberman_blocked;
   logic       scan_done;
   logic [1:0] fsm_state;

   logic [1:0] tile_mem [0:813];

   int         n_total;
   int         n_pass;
   logic [3:0] exp_blocked_now;
   int         last_addr;

   bomberman_collision dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .b_x               (b_x),
      .b_y               (b_y),
      .map_rd_en         (map_rd_en),
      .map_addr          (map_addr),
      .map_rd_data       (map_rd_data),
      .bomberman_blocked (bomberman_blocked),
      .scan_done         (scan_done),
      .fsm_state         (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous-read tile RAM
   initial map_rd_data = 2'd0;
   always @(posedge clk)
      if (map_rd_en) map_rd_data <= tile_mem[map_addr];

   // reference model: probe geometry straight from the edge-pixel rules
   function automatic int probe_x(input int x, input int k);
      case (k)
         0, 1: return x - 1;
         2, 3: return x + 16;
         4, 6: return x;
         default: return x + 15;
      endcase
   endfunction

   function automatic int probe_y(input int y, input int k);
      case (k)
         0, 2: return y;
         1, 3: return y + 15;
         4, 5: return y - 1;
         default: return y + 16;
      endcase
   endfunction

   function automatic bit in_map(input int px, input int py);
      return (px >= 144) && (px < 144 + 37 * 16) && (py >= 144) && (py < 144 + 22 * 16);
   endfunction

   function automatic int tile_index(input int px, input int py);
      return ((py - 144) / 16) * 37 + (px - 144) / 16;
   endfunction

   function automatic logic [3:0] model_blocked(input int x, input int y);
      logic [3:0] b;
      int px, py;
      bit h;
      b = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         px = probe_x(x, k);
         py = probe_y(y, k);
         h  = !in_map(px, py) || (tile_mem[tile_index(px, py)] != 2'd0);
         if (h) b[k / 2] = 1'b1;
      end
      return b;
   endfunction

   // scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_map();
      for (int i = 0; i < 814; i++) tile_mem[i] = 2'd0;
   endtask

   // driver: call at a negedge with the DUT in IDLE; returns at the negedge showing the result
   task automatic do_scan(input string name, input int x, input int y,
                          input int chg_k, input int new_x, input bit drop_en);
      logic [3:0] exp_b;
      int px, py;
      b_x    = 10'(x);
      b_y    = 10'(y);
      enable = 1'b1;
      exp_b  = model_blocked(x, y);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         px = probe_x(x, k);
         py = probe_y(y, k);
         check($sformatf("%s_rd_en_k%0d", name, k), map_rd_en, in_map(px, py));
         if (in_map(px, py)) last_addr = tile_index(px, py);
         check($sformatf("%s_addr_k%0d", name, k), map_addr, last_addr);
         check($sformatf("%s_hold_k%0d", name, k), bomberman_blocked, exp_blocked_now);
         check($sformatf("%s_done_k%0d", name, k), scan_done, 1'b0);
         if (k == chg_k) b_x = 10'(new_x);
         if (drop_en && k == 2) enable = 1'b0;
      end
      @(negedge clk);
      check({name, "_wait_rd_en"}, map_rd_en, 1'b0);
      @(negedge clk);
      check({name, "_upd_done"}, scan_done, 1'b0);
      check({name, "_upd_hold"}, bomberman_blocked, exp_blocked_now);
      @(negedge clk);
      check({name, "_done"}, scan_done, 1'b1);
      check({name, "_blocked"}, bomberman_blocked, exp_b);
      exp_blocked_now = exp_b;
   endtask

   initial begin
      n_total         = 0;
      n_pass          = 0;
      exp_blocked_now = 4'b1111;
      last_addr       = 0;
      reset           = 1'b0;
      enable          = 1'b0;
      b_x             = 10'd176;
      b_y             = 10'd176;
      clear_map();

      // reset state
      #12;
      check("rst_blocked", bomberman_blocked, 4'b1111);
      check("rst_done", scan_done, 1'b0);
      check("rst_rd_en", map_rd_en, 1'b0);
      check("rst_addr", map_addr, 10'd0);
      @(negedge clk);
      reset = 1'b1;

      // idle holds while disabled
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_done", scan_done, 1'b0);
         check("idle_rd_en", map_rd_en, 1'b0);
         check("idle_blocked", bomberman_blocked, 4'b1111);
      end

      // empty map, back-to-back scans 11 cycles apart
      do_scan("empty1", 176, 176, -1, 0, 1'b0);
      check("empty1_const", bomberman_blocked, 4'b0000);
      do_scan("empty2", 176, 176, -1, 0, 1'b0);

      // hard wall left of the sprite
      tile_mem[75] = 2'd1;
      do_scan("hard", 176, 176, -1, 0, 1'b0);
      check("hard_const", bomberman_blocked, 4'b0001);

      // spawn against the arena's left edge
      clear_map();
      do_scan("spawn", 144, 400, -1, 0, 1'b0);
      check("spawn_const", bomberman_blocked, 4'b0001);

      // unaligned sprite, soft block below
      clear_map();
      tile_mem[113] = 2'd2;
      do_scan("unalign", 176, 180, -1, 0, 1'b0);
      check("unalign_const", bomberman_blocked, 4'b1000);

      // position change mid-scan uses the snapshot; bomb counts as blocked
      clear_map();
      tile_mem[75] = 2'd3;
      do_scan("snap", 176, 176, 3, 177, 1'b0);
      check("snap_const", bomberman_blocked, 4'b0001);
      do_scan("snap_next", 177, 176, -1, 0, 1'b0);

      // enable dropped mid-scan: scan completes, then parks
      tile_mem[76] = 2'd1;
      do_scan("drop", 177, 176, -1, 0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("park_done", scan_done, 1'b0);
         check("park_rd_en", map_rd_en, 1'b0);
         check("park_state", fsm_state, 2'd0);
         check("park_blocked", bomberman_blocked, exp_blocked_now);
      end

      // async reset during probe k=5
      clear_map();
      b_x    = 10'd300;
      b_y    = 10'd300;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_blocked", bomberman_blocked, 4'b1111);
      check("midrst_done", scan_done, 1'b0);
      check("midrst_rd_en", map_rd_en, 1'b0);
      check("midrst_addr", map_addr, 10'd0);
      exp_blocked_now = 4'b1111;
      last_addr       = 0;
      @(negedge clk);
      reset = 1'b1;
      do_scan("post_rst", 300, 300, -1, 0, 1'b0);

      // randomized maps and positions
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < 814; i++)
            tile_mem[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         do_scan($sformatf("rnd%0d", it), $urandom_range(100, 760), $urandom_range(100, 520),
                 -1, 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
